// File: rtl/video_timing_pattern_gen_if.sv
// Video raster output bundle: timing strobes, pixel position and 24-bit RGB.
// The master drives it; encoders and monitors attach as slaves.
interface video_timing_pattern_gen_if #(
  parameter int unsigned CntWidth = 11
);
  logic                den_o;
  logic                hsync_o;
  logic                vsync_o;
  logic                sof_o;
  logic [CntWidth-1:0] x_o;
  logic [CntWidth-1:0] y_o;
  logic [23:0]         rgb_o;

  modport master (output den_o, hsync_o, vsync_o, sof_o, x_o, y_o, rgb_o);
  modport slave  (input  den_o, hsync_o, vsync_o, sof_o, x_o, y_o, rgb_o);
endinterface

// File: rtl/video_timing_pattern_gen.sv
// Parametrised DVI/VGA raster timing generator with a registered RGB test pattern.
// All state advances on pixel-strobe cycles only; outputs lag the counters by one strobe.
module video_timing_pattern_gen #(
  parameter int unsigned ColActive = 640,
  parameter int unsigned ColFront  = 16,
  parameter int unsigned ColSync   = 96,
  parameter int unsigned ColBack   = 48,
  parameter int unsigned RowActive = 480,
  parameter int unsigned RowFront  = 10,
  parameter int unsigned RowSync   = 2,
  parameter int unsigned RowBack   = 33,
  parameter logic        HsyncPol  = 1'b0,
  parameter logic        VsyncPol  = 1'b0,
  parameter logic [23:0] SolidRgb  = 24'h0000FF,
  parameter int unsigned CntWidth  = 11
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] mode_i,
  video_timing_pattern_gen_if.master vid
);

  typedef enum logic [1:0] {
    ModeChecker = 2'd0,
    ModeBars    = 2'd1,
    ModeRamp    = 2'd2,
    ModeSolid   = 2'd3
  } mode_e;

  localparam int unsigned ColTotal = ColActive + ColFront + ColSync + ColBack;
  localparam int unsigned RowTotal = RowActive + RowFront + RowSync + RowBack;
  localparam int unsigned BarWidth = ColActive / 8;

  localparam logic [CntWidth-1:0] ColLast    = CntWidth'(ColTotal - 1);
  localparam logic [CntWidth-1:0] RowLast    = CntWidth'(RowTotal - 1);
  localparam logic [CntWidth-1:0] ColActEnd  = CntWidth'(ColActive);
  localparam logic [CntWidth-1:0] RowActEnd  = CntWidth'(RowActive);
  localparam logic [CntWidth-1:0] HsStart    = CntWidth'(ColActive + ColFront);
  localparam logic [CntWidth-1:0] HsEnd      = CntWidth'(ColActive + ColFront + ColSync);
  localparam logic [CntWidth-1:0] VsStart    = CntWidth'(RowActive + RowFront);
  localparam logic [CntWidth-1:0] VsEnd      = CntWidth'(RowActive + RowFront + RowSync);
  localparam logic [CntWidth-1:0] BarLast    = CntWidth'(BarWidth - 1);

  logic [CntWidth-1:0] col_q, row_q, sub_q;
  logic [CntWidth-1:0] col_d, row_d, sub_d;
  logic [2:0]          bar_q, bar_d;
  mode_e               mode_q, mode_cur;
  logic                col_wrap, frame_start;
  logic                den_d, hsync_d, vsync_d;
  logic [23:0]         pix, rgb_d;

  logic                den_q, hsync_q, vsync_q, sof_q;
  logic [CntWidth-1:0] x_q, y_q;
  logic [23:0]         rgb_q;

  assign col_wrap    = (col_q == ColLast);
  assign frame_start = (col_q == '0) && (row_q == '0);
  // The first pixel of a frame already uses the newly sampled mode, so no frame tears.
  assign mode_cur    = frame_start ? mode_e'(mode_i) : mode_q;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    col_d = col_q + 1'b1;
    row_d = row_q;
    sub_d = sub_q + 1'b1;
    bar_d = bar_q;
    if (col_wrap) begin
      col_d = '0;
      row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
      sub_d = '0;
      bar_d = '0;
    end else if (sub_q == BarLast) begin
      sub_d = '0;
      bar_d = (bar_q == 3'd7) ? 3'd7 : bar_q + 3'd1;
    end

    den_d   = (col_q < ColActEnd) && (row_q < RowActEnd);
    hsync_d = ((col_q >= HsStart) && (col_q < HsEnd)) ? HsyncPol : ~HsyncPol;
    vsync_d = ((row_q >= VsStart) && (row_q < VsEnd)) ? VsyncPol : ~VsyncPol;

    pix = '0;
    unique case (mode_cur)
      ModeChecker: pix = (col_q[5] ^ row_q[5]) ? 24'hFFFFFF : 24'h000000;
      ModeBars:    pix = {{8{~bar_q[1]}}, {8{~bar_q[2]}}, {8{~bar_q[0]}}};
      ModeRamp:    pix = {3{col_q[7:0]}};
      ModeSolid:   pix = SolidRgb;
      default:     pix = '0;
    endcase
    rgb_d = den_d ? pix : '0;
  end

  // NOTE: state and output registers use non-blocking assignments so every flop
  // samples the pre-edge value of the others.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q   <= '0;
      row_q   <= '0;
      sub_q   <= '0;
      bar_q   <= '0;
      mode_q  <= ModeChecker;
      den_q   <= 1'b0;
      hsync_q <= ~HsyncPol;
      vsync_q <= ~VsyncPol;
      sof_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      rgb_q   <= '0;
    end else begin
      // sof is a single-clock pulse even when the strobe is sparse.
      sof_q <= 1'b0;
      if (en_i) begin
        col_q   <= col_d;
        row_q   <= row_d;
        sub_q   <= sub_d;
        bar_q   <= bar_d;
        mode_q  <= mode_cur;
        den_q   <= den_d;
        hsync_q <= hsync_d;
        vsync_q <= vsync_d;
        sof_q   <= frame_start;
        x_q     <= col_q;
        y_q     <= row_q;
        rgb_q   <= rgb_d;
      end
    end
  end

  assign vid.den_o   = den_q;
  assign vid.hsync_o = hsync_q;
  assign vid.vsync_o = vsync_q;
  assign vid.sof_o   = sof_q;
  assign vid.x_o     = x_q;
  assign vid.y_o     = y_q;
  assign vid.rgb_o   = rgb_q;

endmodule
